// File: rtl/div_unit.sv
// div_unit: sequential 32-bit signed/unsigned divider with a start/busy/done handshake.
// Radix-2 restoring division on operand magnitudes, then sign correction.
// Div_result = {remainder, quotient}; holds until the next completed operation.
// Build option: DIV_ZERO_FAST_EN skips the iterations when the divisor is zero.
//
// state | meaning
// IDLE  | waiting for an accepted start; busy=0
// CALC  | one restoring iteration per cycle, WIDTH cycles
// FIX   | apply signs, write Div_result, pulse done
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   srcA,
    input  logic [WIDTH-1:0]   srcB,
    input  logic               ctrl,
    input  logic               start,
    input  logic               cancel,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] Div_result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } divState_t;

    divState_t state;
    divState_t stateNext;

    logic [WIDTH-1:0] remReg;
    logic [WIDTH-1:0] quoReg;
    logic [WIDTH-1:0] magB;
    logic [5:0]       iterCnt;
    logic             qNeg;
    logic             rNeg;

    logic             accept;
    logic             lastIter;
    logic             fastZero;
    logic [WIDTH-1:0] magA;
    logic [WIDTH-1:0] magBIn;
    logic [WIDTH:0]   remShift;
    logic             trialOk;
    logic [WIDTH-1:0] remSub;
    logic [WIDTH-1:0] qRes;
    logic [WIDTH-1:0] rRes;

    assign accept   = (state == IDLE) && start && !cancel;
    assign lastIter = (iterCnt == 6'(WIDTH - 1));
    assign busy     = (state != IDLE);

`ifdef DIV_ZERO_FAST_EN
    assign fastZero = (magB == '0);
`else
    assign fastZero = 1'b0;
`endif

    assign magA   = (ctrl && srcA[WIDTH-1]) ? (~srcA + 1'b1) : srcA;
    assign magBIn = (ctrl && srcB[WIDTH-1]) ? (~srcB + 1'b1) : srcB;

    // The shifted partial remainder needs one extra bit; the kept remainder
    // is always below the divisor, so it fits back into WIDTH bits.
    assign remShift = {remReg, quoReg[WIDTH-1]};
    assign trialOk  = (remShift >= {1'b0, magB});
    assign remSub   = remShift[WIDTH-1:0] - magB;

    assign qRes = qNeg ? (~quoReg + 1'b1) : quoReg;
    assign rRes = rNeg ? (~remReg + 1'b1) : remReg;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state decode; cancel always wins over progress
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (accept) stateNext = CALC;
            end
            CALC: begin
                if (cancel)        stateNext = IDLE;
                else if (fastZero) stateNext = FIX;
                else if (lastIter) stateNext = FIX;
            end
            FIX: begin
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Operand capture and restoring-division datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remReg  <= '0;
            quoReg  <= '0;
            magB    <= '0;
            iterCnt <= '0;
            qNeg    <= 1'b0;
            rNeg    <= 1'b0;
        end else if (accept) begin
            remReg  <= '0;
            quoReg  <= magA;
            magB    <= magBIn;
            iterCnt <= '0;
            qNeg    <= ctrl & (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
            rNeg    <= ctrl & srcA[WIDTH-1];
        end else if ((state == CALC) && !cancel) begin
            if (fastZero) begin
                // Same values the full run would reach with a zero divisor.
                quoReg <= '1;
                remReg <= quoReg;
            end else begin
                quoReg  <= {quoReg[WIDTH-2:0], trialOk};
                remReg  <= trialOk ? remSub : remShift[WIDTH-1:0];
                iterCnt <= iterCnt + 6'd1;
            end
        end
    end

    // Result write and one-cycle done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done       <= 1'b0;
            Div_result <= '0;
        end else begin
            done <= 1'b0;
            if ((state == FIX) && !cancel) begin
                done       <= 1'b1;
                Div_result <= {rRes, qRes};
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed testbench for div_unit.
module tb_div_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        ctrl;
    logic        start;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [63:0] Div_result;

    int passCnt  = 0;
    int totalCnt = 0;

`ifdef DIV_ZERO_FAST_EN
    localparam int ZERO_LAT = 2;
`else
    localparam int ZERO_LAT = 33;
`endif

    div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .srcA       (srcA),
        .srcB       (srcB),
        .ctrl       (ctrl),
        .start      (start),
        .cancel     (cancel),
        .busy       (busy),
        .done       (done),
        .Div_result (Div_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        totalCnt++;
        assert (observed === expected) passCnt++;
        else $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    endtask

    // Called at a negedge; returns at the negedge just after the accepting edge.
    task automatic startOp(input logic [31:0] a, input logic [31:0] b, input logic c);
        srcA  = a;
        srcB  = b;
        ctrl  = c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts edges from the accepting edge to done; optionally pokes a start while busy.
    task automatic waitDone(input string tag, input int expLat, input logic [63:0] expRes, input int pokeAt);
        int   lat;
        logic busyOk;
        lat    = 0;
        busyOk = 1'b1;
        while (!done && lat < 100) begin
            if (!busy) busyOk = 1'b0;
            if (lat == pokeAt) begin
                start = 1'b1;
                srcA  = 32'd50;
                srcB  = 32'd5;
                ctrl  = 1'b0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check({tag, "_lat"}, 64'(lat), 64'(expLat));
        check({tag, "_busyHeld"}, {63'd0, busyOk}, 64'd1);
        check({tag, "_res"}, Div_result, expRes);
        check({tag, "_busyAtDone"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        logic sawDone;
        rst_n  = 1'b0;
        srcA   = '0;
        srcB   = '0;
        ctrl   = 1'b0;
        start  = 1'b0;
        cancel = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_res", Div_result, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        startOp(32'd100, 32'd7, 1'b0);
        waitDone("u100_7", 33, {32'd2, 32'd14}, -1);
        @(negedge clk);
        check("u100_7_donePulse", {63'd0, done}, 64'd0);

        startOp(32'hFFFF_FFF9, 32'd2, 1'b1);
        waitDone("sNeg7_2", 33, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, -1);

        startOp(32'd7, 32'hFFFF_FFFE, 1'b1);
        waitDone("s7_neg2", 33, {32'd1, 32'hFFFF_FFFD}, -1);

        startOp(32'hFFFF_FFFF, 32'd1, 1'b0);
        waitDone("uMax_1", 33, {32'd0, 32'hFFFF_FFFF}, -1);

        startOp(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        waitDone("sOvf", 33, {32'd0, 32'h8000_0000}, -1);

        startOp(32'h8000_0000, 32'd3, 1'b0);
        waitDone("uBig_3", 33, {32'd2, 32'h2AAA_AAAA}, -1);

        startOp(32'h1234_5678, 32'd0, 1'b0);
        waitDone("uDiv0", ZERO_LAT, {32'h1234_5678, 32'hFFFF_FFFF}, -1);

        startOp(32'hFFFF_FFFB, 32'd0, 1'b1);
        waitDone("sDiv0", ZERO_LAT, {32'hFFFF_FFFB, 32'd1}, -1);

        // cancel at the tenth CALC iteration
        startOp(32'd1000, 32'd3, 1'b0);
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_busy", {63'd0, busy}, 64'd0);
        check("cancel_done", {63'd0, done}, 64'd0);
        sawDone = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) sawDone = 1'b1;
        end
        check("cancel_noDone", {63'd0, sawDone}, 64'd0);
        check("cancel_resHeld", Div_result, {32'hFFFF_FFFB, 32'd1});

        // cancel together with start in IDLE is not accepted
        srcA   = 32'd9;
        srcB   = 32'd3;
        ctrl   = 1'b0;
        start  = 1'b1;
        cancel = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        cancel = 1'b0;
        check("idleCancel_busy", {63'd0, busy}, 64'd0);

        // start while busy is dropped, not queued
        startOp(32'd9, 32'd3, 1'b0);
        waitDone("u9_3", 33, {32'd0, 32'd3}, 5);
        @(negedge clk);
        check("noQueue_busy", {63'd0, busy}, 64'd0);

        // back-to-back starts issued in the done cycle
        startOp(32'd1000, 32'd10, 1'b0);
        waitDone("b2b_1", 33, {32'd0, 32'd100}, -1);
        startOp(32'd50, 32'hFFFF_FFFB, 1'b1);
        waitDone("b2b_2", 33, {32'd0, 32'hFFFF_FFF6}, -1);
        startOp(32'hFFFF_FF9C, 32'd7, 1'b1);
        waitDone("b2b_3", 33, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, -1);

        // asynchronous reset in the middle of CALC
        startOp(32'd100, 32'd7, 1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midRst_busy", {63'd0, busy}, 64'd0);
        check("midRst_done", {63'd0, done}, 64'd0);
        check("midRst_res", Div_result, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sawDone = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) sawDone = 1'b1;
        end
        check("midRst_quiet", {63'd0, sawDone}, 64'd0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
